// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32I unified-memory arbiter: Mem_OP codes,
// arbiter FSM states and requester identifiers.
package rv_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_IF = 2'b01,
    ST_BUSY_LS = 2'b10
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational byte-lane steering for the memory arbiter: byte enables,
// store-data replication, load extraction/extension and alignment checks.
module rv_lsu_align
  import rv_mem_pkg::*;
(
  input  logic        fetch,
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables, replicated store data and the misalignment/illegal flag.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    err       = 1'b0;
    if (fetch) begin
      be  = 4'b1111;
      err = (addr_lo != 2'b00);
    end else begin
      case (op)
        MEM_B, MEM_BU: begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        MEM_H, MEM_HU: begin
          be        = 4'b0011 << addr_lo;
          wdata_rep = {2{wdata[15:0]}};
          err       = addr_lo[0];
        end
        MEM_W: begin
          be        = 4'b1111;
          wdata_rep = wdata;
          err       = (addr_lo != 2'b00);
        end
        default: err = ~op_is_legal(op);
      endcase
    end
  end

  // Lane selection for the read word.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Sign or zero extension of the selected lane.
  always_comb begin
    rdata_ext = 32'h0000_0000;
    if (fetch) begin
      rdata_ext = rdata;
    end else begin
      case (op)
        MEM_B:   rdata_ext = {{24{byte_s[7]}}, byte_s};
        MEM_BU:  rdata_ext = {24'h00_0000, byte_s};
        MEM_H:   rdata_ext = {{16{half_s[15]}}, half_s};
        MEM_HU:  rdata_ext = {16'h0000, half_s};
        MEM_W:   rdata_ext = rdata;
        default: rdata_ext = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch and load/store,
// with LS priority, registered memory port and an ack watchdog.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state_r;
  logic [CW-1:0] wd_cnt_r;
  logic [2:0]    op_r;
  logic [1:0]    addr_lo_r;

  logic        idle_s;
  logic        fetch_sel_s;
  logic [2:0]  op_sel_s;
  logic [31:0] addr_sel_s;
  logic [1:0]  lo_sel_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] rdata_ext_s;
  logic        align_err_s;
  logic        timeout_s;

  assign idle_s = (state_r == ST_IDLE);

  // Fixed-priority grant: LS beats IF, only from IDLE.
  always_comb begin
    if (idle_s) begin
      ls_gnt = ls_req;
      if_gnt = if_req & ~ls_req;
    end else begin
      ls_gnt = 1'b0;
      if_gnt = 1'b0;
    end
  end

  // The aligner sees the live winner at grant time and the latched fields while busy.
  always_comb begin
    addr_sel_s = ls_req ? ls_addr : if_addr;
    if (idle_s) begin
      fetch_sel_s = ~ls_req;
      op_sel_s    = ls_op;
      lo_sel_s    = addr_sel_s[1:0];
    end else begin
      fetch_sel_s = (state_r == ST_BUSY_IF);
      op_sel_s    = op_r;
      lo_sel_s    = addr_lo_r;
    end
  end

  rv_lsu_align u_align (
    .fetch     (fetch_sel_s),
    .op        (op_sel_s),
    .addr_lo   (lo_sel_s),
    .wdata     (ls_wdata),
    .rdata     (mem_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s),
    .err       (align_err_s)
  );

  // The current BUSY cycle is the TIMEOUT-th one without an ack.
  always_comb begin
    if (TIMEOUT != 0) begin
      timeout_s = ((32'(wd_cnt_r) + 32'd1) == 32'(TIMEOUT));
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Arbiter FSM with registered memory port, completion pulses and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      wd_cnt_r  <= '0;
      op_r      <= 3'b000;
      addr_lo_r <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      if_valid  <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'h0000_0000;
      ls_valid  <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= 32'h0000_0000;
    end else begin
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      ls_valid <= 1'b0;
      ls_err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ls_gnt || if_gnt) begin
            if (align_err_s) begin
              ls_err <= ls_gnt;
              if_err <= if_gnt;
            end else begin
              state_r   <= ls_gnt ? ST_BUSY_LS : ST_BUSY_IF;
              wd_cnt_r  <= '0;
              op_r      <= op_sel_s;
              addr_lo_r <= lo_sel_s;
              mem_req   <= 1'b1;
              mem_we    <= ls_gnt & ls_we;
              mem_be    <= be_s;
              mem_addr  <= {addr_sel_s[31:2], 2'b00};
              mem_wdata <= ls_gnt ? wdata_rep_s : 32'h0000_0000;
            end
          end
        end
        ST_BUSY_IF, ST_BUSY_LS: begin
          if (mem_ack || timeout_s) begin
            state_r   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            if (mem_ack) begin
              if (state_r == ST_BUSY_IF) begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
              end else begin
                ls_valid <= 1'b1;
                ls_rdata <= mem_we ? 32'h0000_0000 : rdata_ext_s;
              end
            end else begin
              if_err <= (state_r == ST_BUSY_IF);
              ls_err <= (state_r == ST_BUSY_LS);
            end
          end else begin
            wd_cnt_r <= wd_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
